// File: rtl/vram_fetch_pkg.sv
// Shared types and constants for the VRAM port-2 fetch unit.
package vram_fetch_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vram_fetch_byte_fifo.sv
// Synchronous byte FIFO with flush; head reads as zero while empty.
module byte_fifo
    import vram_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = VRAM_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DW-1:0]              head,
    output logic                       not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign not_empty = (count != '0);
    assign head      = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vram_fetch.sv
// Port-2 line fetcher: walks a byte run of VRAM one read per access slot into a byte FIFO.
// Optional underflow statistics counter enabled by defining VRAM_FETCH_STATS_EN.
//
// state | meaning
// IDLE  | no run active
// FETCH | reads still to be issued for the current run
// DRAIN | all reads issued, waiting for the last byte to return
module vram_fetch
    import vram_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int RD_LATENCY = 2,
    parameter int LEN_W      = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 slot,
    input  logic                 line_start,
    input  logic [VRAM_AW-1:0]   line_base,
    input  logic [LEN_W-1:0]     line_len,
    output logic [VRAM_AW-1:0]   rd_addr,
    input  logic [VRAM_DW-1:0]   rd_data,
    output logic [VRAM_DW-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 line_done
`ifdef VRAM_FETCH_STATS_EN
    ,
    output logic [15:0]          underflow_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    state_t                state;
    logic [LEN_W-1:0]      remaining;
    logic [RD_LATENCY-1:0] pipe;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic                  abort;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  last_push;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

    // Bytes already buffered plus reads still in flight must fit, so the FIFO never overflows.
    assign abort     = line_start && busy;
    assign issue     = (state == FETCH) && slot && !line_start &&
                       (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C);
    assign push      = slot && pipe[RD_LATENCY-1] && !line_start;
    assign pop       = out_valid && out_ready && !abort;
    assign last_push = (state == DRAIN) && push && (inflight == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            pipe      <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (slot) pipe <= (pipe << 1) | RD_LATENCY'(issue);
            if (line_start) begin
                pipe <= '0;
                if (line_len == '0) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    line_done <= 1'b1;
                end else begin
                    state     <= FETCH;
                    busy      <= 1'b1;
                    rd_addr   <= line_base;
                    remaining <= line_len;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (issue) begin
                            rd_addr   <= rd_addr + VRAM_AW'(1);
                            remaining <= remaining - LEN_W'(1);
                            if (remaining == LEN_W'(1)) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (last_push) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            line_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (VRAM_DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (out_data),
        .not_empty (out_valid)
    );

`ifdef VRAM_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_cnt <= '0;
        end else if (busy && out_ready && !out_valid && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_fetch.sv
// Scoreboard bench for vram_fetch with a slot-timed VRAM model and random runs.
module tb_vram_fetch;

    localparam int LEN_W = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slot = 1'b0;
    logic        line_start = 1'b0;
    logic [15:0] line_base = '0;
    logic [LEN_W-1:0] line_len = '0;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        line_done;
`ifdef VRAM_FETCH_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    vram_fetch #(.FIFO_DEPTH(16), .RD_LATENCY(2), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .slot       (slot),
        .line_start (line_start),
        .line_base  (line_base),
        .line_len   (line_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .line_done  (line_done)
`ifdef VRAM_FETCH_STATS_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ld_seen = 0;
    int ld_exp = 0;
    int slot_div = 2;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic abort_now = 1'b0;
    logic [7:0] exp_q [$];
    logic [15:0] hist0 = '0;
    logic [15:0] hist1 = '0;

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // VRAM answers RD_LATENCY=2 slots after it samples the address.
    always @(posedge clk) begin
        if (slot) begin
            hist1 <= hist0;
            hist0 <= rd_addr;
        end
    end
    assign rd_data = ram_byte(hist1);

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    initial begin : slot_gen
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (cnt >= slot_div - 1) begin
                slot = 1'b1;
                cnt = 0;
            end else begin
                slot = 1'b0;
                cnt++;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (line_done) ld_seen++;
                if (out_valid && out_ready && !abort_now) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(out_data), int'(e));
                    end
                end
            end
        end
    end

    task automatic start_line(input logic [15:0] b, input int n, input bit abort);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_base  = b;
        line_len   = LEN_W'(n);
        abort_now  = abort;
        if (abort) exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(ram_byte(b + 16'(i)));
        ld_exp++;
        @(posedge clk); #1;
        line_start = 1'b0;
        abort_now  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (!busy && exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk(name, int'(done), 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_rd_addr"}, int'(rd_addr), 0);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_out_data"}, int'(out_data), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_line_done"}, int'(line_done), 0);
`ifdef VRAM_FETCH_STATS_EN
        chk({name, "_underflow"}, int'(underflow_cnt), 0);
`endif
    endtask

    initial begin : stimulus
        logic [15:0] addr_before;
        reset = 1'b1;
        wait_cycles(3);
        check_reset_state("reset");
        reset = 1'b0;
        wait_cycles(2);

        // basic run
        slot_div = 2; ready_mode = 1;
        start_line(16'h1000, 4, 0);
        chk("t1_rd_addr_load", int'(rd_addr), 16'h1000);
        chk("t1_busy", int'(busy), 1);
        wait_done("t1_done", 200);
        chk("t1_busy_low", int'(busy), 0);
        chk("t1_rd_addr_end", int'(rd_addr), 16'h1004);

        // address wrap
        start_line(16'hFFFE, 4, 0);
        wait_done("t2_done", 200);
        chk("t2_rd_addr_end", int'(rd_addr), 16'h0002);

        // backpressure: issues stop with 16 bytes buffered or in flight
        ready_mode = 0;
        start_line(16'h3000, 40, 0);
        wait_cycles(140);
        chk("t3_rd_addr_stall", int'(rd_addr), 16'h3010);
        chk("t3_busy", int'(busy), 1);
        chk("t3_valid", int'(out_valid), 1);
        ready_mode = 1;
        wait_done("t3_done", 500);

        // abort with a second line_start
        start_line(16'h4000, 20, 0);
        wait_cycles(10);
        ld_exp--;
        start_line(16'h2000, 2, 1);
        wait_done("t4_done", 200);

        // reset in the middle of a run
        ready_mode = 0;
        start_line(16'h5000, 20, 0);
        wait_cycles(12);
        reset = 1'b1;
        ld_exp--;
        exp_q.delete();
        wait_cycles(1);
        check_reset_state("t5");
        reset = 1'b0;
        ready_mode = 1;
        wait_cycles(12);
        chk("t5_post_idle_valid", int'(out_valid), 0);
        chk("t5_post_idle_busy", int'(busy), 0);

        // empty run
        addr_before = rd_addr;
        start_line(16'h7777, 0, 0);
        chk("t6_line_done", int'(line_done), 1);
        chk("t6_rd_addr_hold", int'(rd_addr), int'(addr_before));
        chk("t6_busy", int'(busy), 0);
        wait_cycles(1);
        chk("t6_line_done_pulse", int'(line_done), 0);
        chk("t6_valid", int'(out_valid), 0);

        // throttled slots with an eager consumer
        slot_div = 8;
        start_line(16'h6000, 6, 0);
        wait_done("t6_slow_done", 400);
`ifdef VRAM_FETCH_STATS_EN
        chk("t6_underflow_nonzero", int'(underflow_cnt != 16'd0), 1);
`endif

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            slot_div   = $urandom_range(1, 4);
            ready_mode = $urandom_range(1, 2);
            start_line(16'($urandom), $urandom_range(1, 50), 0);
            wait_done("rand_done", 3000);
        end

        ready_mode = 1;
        wait_cycles(4);
        chk("line_done_total", ld_seen, ld_exp);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
